// File: rtl/trans_pkg.sv
// Shared definitions for the transaction path: word geometry, field offsets
// and the packed transaction layout.
package trans_pkg;

  localparam int TRANS_W         = 128;
  localparam int BYTES_PER_TRANS = 16;
  localparam int BIT_BLOCK_START = 9;

  localparam int SENDER_MSB   = 127;
  localparam int SENDER_LSB   = 80;
  localparam int RECEIVER_MSB = 79;
  localparam int RECEIVER_LSB = 32;
  localparam int AMOUNT_MSB   = 31;
  localparam int AMOUNT_LSB   = 10;

  // flags[9] carries the block-start marker; the rest are unused here.
  typedef struct packed {
    logic [SENDER_MSB-SENDER_LSB:0]     sender;
    logic [RECEIVER_MSB-RECEIVER_LSB:0] receiver;
    logic [AMOUNT_MSB-AMOUNT_LSB:0]     amount;
    logic [AMOUNT_LSB-1:0]              flags;
  } trans_t;

endpackage

// File: rtl/trans_assembler_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read and an occupancy count.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; contents are only visible while level is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trans_assembler.sv
// Frames an MSB-first byte stream into 128-bit transactions, stamps the
// block-start flag, counts discarded partial frames and queues finished words.
module trans_assembler #(
  parameter int DEPTH           = 8,
  parameter int BIT_BLOCK_START = trans_pkg::BIT_BLOCK_START
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  input  logic                   byte_sof_i,
  output logic                   byte_ready_o,
  input  logic                   block_start_i,
  output logic [127:0]           data_o,
  output logic                   valid_o,
  input  logic                   ack_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [15:0]            drop_cnt_o
);

  import trans_pkg::*;

  localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_TRANS - 1);

  logic [3:0]           byte_cnt;
  logic [TRANS_W-9:0]   sh;
  logic                 pending_blk;
  logic                 accept;
  logic                 push;
  logic                 full;
  logic                 empty;
  logic [TRANS_W-1:0]   push_word;

  assign byte_ready_o = !full;
  assign valid_o      = !empty;
  assign accept       = byte_valid_i && byte_ready_o;
  // A sof on the 16th slot restarts the frame instead of completing it.
  assign push         = accept && !byte_sof_i && (byte_cnt == LAST_BYTE);

  always_comb begin
    push_word = {sh, byte_i};
    push_word[BIT_BLOCK_START] = push_word[BIT_BLOCK_START] | pending_blk | block_start_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt    <= '0;
      sh          <= '0;
      pending_blk <= 1'b0;
      drop_cnt_o  <= '0;
    end else begin
      if (push)               pending_blk <= 1'b0;
      else if (block_start_i) pending_blk <= 1'b1;

      if (accept) begin
        if (byte_sof_i) begin
          if (byte_cnt != '0 && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
          sh       <= {sh[TRANS_W-17:0], byte_i};
          byte_cnt <= 4'd1;
        end else if (byte_cnt == LAST_BYTE) begin
          byte_cnt <= '0;
        end else if (byte_cnt != '0) begin
          sh       <= {sh[TRANS_W-17:0], byte_i};
          byte_cnt <= byte_cnt + 4'd1;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (TRANS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_word),
    .pop   (ack_i),
    .rdata (data_o),
    .level (level_o),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_trans_assembler.sv
// Self-checking bench for trans_assembler: a byte-level reference model pushes
// expected words into a scoreboard queue that is drained as the DUT presents them.
module tb_trans_assembler;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_i;
  logic         byte_valid_i;
  logic         byte_sof_i;
  logic         byte_ready_o;
  logic         block_start_i;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i;
  logic [3:0]   level_o;
  logic [15:0]  drop_cnt_o;

  trans_assembler #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .byte_sof_i    (byte_sof_i),
    .byte_ready_o  (byte_ready_o),
    .block_start_i (block_start_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ack_i         (ack_i),
    .level_o       (level_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] exp_q[$];
  logic [3:0]   m_cnt;
  logic [119:0] m_sh;
  logic         m_pend;
  logic [15:0]  m_drop;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt  = '0;
    m_sh   = '0;
    m_pend = 1'b0;
    m_drop = '0;
    exp_q.delete();
  endtask

  // Reference framing of one accepted byte.
  task automatic model_byte(input logic [7:0] b, input logic sof);
    logic [127:0] w;
    if (sof) begin
      if (m_cnt != 0 && m_drop != 16'hFFFF) m_drop++;
      m_sh  = {m_sh[111:0], b};
      m_cnt = 4'd1;
    end else if (m_cnt == 4'd15) begin
      w     = {m_sh, b};
      w[9]  = w[9] | m_pend;
      m_pend = 1'b0;
      exp_q.push_back(w);
      m_cnt = '0;
    end else if (m_cnt != 0) begin
      m_sh  = {m_sh[111:0], b};
      m_cnt = m_cnt + 4'd1;
    end
  endtask

  // Drives one byte and holds it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b, input logic sof, input logic with_ack = 1'b0);
    int waited = 0;
    byte_i       = b;
    byte_sof_i   = sof;
    byte_valid_i = 1'b1;
    ack_i        = with_ack;
    while (!byte_ready_o && waited < 100) begin
      tick();
      waited++;
    end
    if (!byte_ready_o) chk("ready_timeout", {127'b0, byte_ready_o}, 128'd1);
    tick();
    model_byte(b, sof);
    byte_valid_i = 1'b0;
    byte_sof_i   = 1'b0;
    ack_i        = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int step);
    for (int k = 0; k < 16; k++) send_byte(8'(base + k * step), k == 0);
  endtask

  task automatic pulse_block();
    block_start_i = 1'b1;
    tick();
    block_start_i = 1'b0;
    m_pend = 1'b1;
  endtask

  task automatic pulse_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  // Compare the head against the scoreboard, then pop it.
  task automatic pop_check(input string tag);
    int waited = 0;
    while (!valid_o && waited < 50) begin
      tick();
      waited++;
    end
    if (!valid_o) chk({tag, "_valid_timeout"}, {127'b0, valid_o}, 128'd1);
    else if (exp_q.size() == 0) chk({tag, "_unexpected"}, {127'b0, valid_o}, 128'd0);
    else begin
      chk(tag, data_o, exp_q.pop_front());
      pulse_ack();
    end
  endtask

  initial begin
    logic [127:0] w_a;
    rst = 1'b1; byte_i = '0; byte_valid_i = 1'b0; byte_sof_i = 1'b0;
    block_start_i = 1'b0; ack_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    chk("rst_valid", {127'b0, valid_o}, 128'd0);
    chk("rst_level", {124'b0, level_o}, 128'd0);
    chk("rst_ready", {127'b0, byte_ready_o}, 128'd1);
    chk("rst_drop",  {112'b0, drop_cnt_o}, 128'd0);

    // Ack while empty must not move anything.
    pulse_ack();
    chk("ack_empty_level", {124'b0, level_o}, 128'd0);

    send_frame(8'h00, 1);
    chk("t1_valid", {127'b0, valid_o}, 128'd1);
    chk("t1_level", {124'b0, level_o}, 128'd1);
    chk("t1_const", data_o, 128'h000102030405060708090A0B0C0D0E0F);
    pop_check("t1_data");
    chk("t1_valid_after_ack", {127'b0, valid_o}, 128'd0);

    pulse_block();
    send_frame(8'h00, 0);
    chk("blk_const", data_o, 128'h200);
    pop_check("blk_data");
    send_frame(8'h00, 0);
    chk("noblk_const", data_o, 128'h0);
    pop_check("noblk_data");

    // Bytes without sof while idle are dropped silently.
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    chk("nosof_level", {124'b0, level_o}, 128'd0);
    chk("nosof_drop",  {112'b0, drop_cnt_o}, 128'd0);

    for (int k = 0; k < 5; k++) send_byte(8'hE0 + 8'(k), k == 0);
    send_frame(8'h40, 3);
    chk("drop_cnt", {112'b0, drop_cnt_o}, {112'b0, m_drop});
    chk("drop_one", {112'b0, drop_cnt_o}, 128'd1);
    chk("drop_level", {124'b0, level_o}, 128'd1);
    pop_check("drop_data");
    chk("drop_empty", {124'b0, level_o}, 128'd0);

    for (int f = 0; f < DEPTH; f++) send_frame(8'(f * 16 + 3), 5);
    chk("full_level", {124'b0, level_o}, 128'd8);
    chk("full_ready", {127'b0, byte_ready_o}, 128'd0);
    byte_i = 8'h77; byte_sof_i = 1'b1; byte_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("held_ready", {127'b0, byte_ready_o}, 128'd0);
      chk("held_level", {124'b0, level_o}, 128'd8);
    end
    byte_valid_i = 1'b0; byte_sof_i = 1'b0;
    chk("full_head", data_o, exp_q.pop_front());
    pulse_ack();
    chk("pop_level", {124'b0, level_o}, 128'd7);
    chk("pop_ready", {127'b0, byte_ready_o}, 128'd1);
    for (int f = 1; f < DEPTH; f++) pop_check("order");
    chk("drain_valid", {127'b0, valid_o}, 128'd0);

    // 16th byte accepted together with a pop of the single queued word.
    send_frame(8'h10, 7);
    chk("sim_level1", {124'b0, level_o}, 128'd1);
    w_a = exp_q.pop_front();
    chk("sim_head_a", data_o, w_a);
    for (int k = 0; k < 15; k++) send_byte(8'h90 + 8'(k), k == 0);
    send_byte(8'hC5, 1'b0, 1'b1);
    chk("sim_level", {124'b0, level_o}, 128'd1);
    pop_check("sim_head_b");

    // Block flag coinciding with the completing byte.
    for (int k = 0; k < 15; k++) send_byte(8'h00, k == 0);
    block_start_i = 1'b1;
    m_pend = 1'b1;
    send_byte(8'h00, 1'b0);
    block_start_i = 1'b0;
    chk("coinc_const", data_o, 128'h200);
    pop_check("coinc_data");
    send_frame(8'h00, 0);
    pop_check("coinc_cleared");

    // Async reset with words queued and a partial frame in flight.
    for (int f = 0; f < 3; f++) send_frame(8'(f + 1), 2);
    for (int k = 0; k < 7; k++) send_byte(8'h55, k == 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {127'b0, valid_o}, 128'd0);
    chk("arst_level", {124'b0, level_o}, 128'd0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    chk("arst_drop", {112'b0, drop_cnt_o}, 128'd0);
    send_frame(8'h21, 1);
    chk("post_rst_level", {124'b0, level_o}, 128'd1);
    pop_check("post_rst_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
